// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file for the RV32I core.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mtval/mcountinhibit, the
// mcycle/minstret/mhpmcounter set, and resolves pending interrupts and the
// handler address for the trap controller.
module csr_unit #(
    parameter int          NUM_HPM   = 4,
    parameter int          CNT_WIDTH = 64,
    parameter bit          VECTORED  = 1'b1,
    parameter logic [31:0] HART_ID   = 32'h0
) (
    input  logic               ctrl_clk,
    input  logic               ctrl_reset_n,
    input  logic [11:0]        raddr,
    output logic [31:0]        rdata,
    output logic               ctrl_addr_valid,
    input  logic               wen,
    input  logic [11:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic [31:0]        trap_pc,
    input  logic [4:0]         trap_info,
    input  logic [2:0]         ctrl_mxip,
    input  logic               ctrl_trap,
    input  logic               ctrl_mret,
    input  logic               ev_retire,
    input  logic [NUM_HPM-1:0] ev_hpm,
    output logic               ctrl_mie,
    output logic               irq_pending,
    output logic [3:0]         irq_cause,
    output logic [31:0]        trap_target,
    output logic [31:0]        mepc_out
);
    localparam int NCNT = 3 + NUM_HPM;
    // Counter slots are indexed by the low five address bits; slot 1 has no counter.
    localparam logic [31:0] CNT_IMPL = 32'((64'd1 << NCNT) - 64'd1) & ~32'h2;

    logic                 mstat_mie;
    logic                 mstat_mpie;
    logic [31:0]          mie_r;
    logic [31:0]          mtvec_r;
    logic [31:0]          mscratch_r;
    logic [31:0]          mepc_r;
    logic [31:0]          mcause_r;
    logic [31:0]          mtval_r;
    logic [31:0]          inhibit_r;
    logic [CNT_WIDTH-1:0] cnt_r [32];

    logic [31:0] mip_val;
    logic [31:0] irq_en;
    logic [31:0] ev_vec;
    logic [31:0] rd_cur;
    logic [31:0] wr_val;
    logic [63:0] rd_cnt;
    logic        wr_ok;
    logic        w_is_cnt;
    logic        w_writable;

    function automatic logic is_cnt_addr(input logic [11:0] a);
        return (a[11:8] == 4'hB) && (a[6:5] == 2'b00) && (a[4:0] != 5'd1);
    endfunction

    function automatic logic mcause_legal(input logic [31:0] v);
        if (v[31])
            return (v[30:0] <= 31'd11) && (v[3:0] != 4'd2) && (v[3:0] != 4'd6) && (v[3:0] != 4'd10);
        return (v[30:0] <= 31'd15) && (v[3:0] != 4'd10) && (v[3:0] != 4'd14);
    endfunction

    // A trap cycle swallows any concurrent CSR write, counters included.
    assign wr_ok    = wen & ~ctrl_trap;
    assign w_is_cnt = is_cnt_addr(waddr);
    assign mip_val  = {20'h0, ctrl_mxip[0], 3'b0, ctrl_mxip[2], 3'b0, ctrl_mxip[1], 3'b0};
    assign irq_en   = mip_val & mie_r;
    assign ev_vec   = 32'({ev_hpm, ev_retire, 1'b0, 1'b1});

    // Current value of the CSR selected by raddr.
    always_comb begin
        rd_cur          = '0;
        ctrl_addr_valid = 1'b1;
        rd_cnt          = 64'(cnt_r[raddr[4:0]]);
        if (is_cnt_addr(raddr)) begin
            rd_cur = raddr[7] ? rd_cnt[63:32] : rd_cnt[31:0];
        end else begin
            case (raddr)
                12'h300: rd_cur = {19'b0, 2'b11, 3'b0, mstat_mpie, 3'b0, mstat_mie, 3'b0};
                12'h301: rd_cur = 32'h4000_0100;
                12'h304: rd_cur = mie_r;
                12'h305: rd_cur = mtvec_r;
                12'h320: rd_cur = inhibit_r;
                12'h340: rd_cur = mscratch_r;
                12'h341: rd_cur = mepc_r;
                12'h342: rd_cur = mcause_r;
                12'h343: rd_cur = mtval_r;
                12'h344: rd_cur = mip_val;
                12'hF14: rd_cur = HART_ID;
                default: ctrl_addr_valid = 1'b0;
            endcase
        end
    end

    // Legalised value the write target will hold (for counters: the written half).
    always_comb begin
        wr_val     = '0;
        w_writable = 1'b0;
        if (w_is_cnt) begin
            w_writable = CNT_IMPL[waddr[4:0]];
            wr_val     = waddr[7] ? 32'(wdata[CNT_WIDTH-33:0]) : wdata;
        end else begin
            w_writable = 1'b1;
            case (waddr)
                12'h300: wr_val = {19'b0, 2'b11, 3'b0, wdata[7], 3'b0, wdata[3], 3'b0};
                12'h304: wr_val = wdata & 32'h0000_0888;
                12'h305: wr_val = (wdata[1:0] == 2'b00 || (wdata[1:0] == 2'b01 && VECTORED)) ? wdata : mtvec_r;
                12'h320: wr_val = wdata & CNT_IMPL;
                12'h340: wr_val = wdata;
                12'h341: wr_val = {wdata[31:2], 2'b00};
                12'h342: wr_val = mcause_legal(wdata) ? wdata : mcause_r;
                12'h343: wr_val = wdata;
                default: w_writable = 1'b0;
            endcase
        end
    end

    // Same-cycle write to the address being read is forwarded.
    assign rdata = (wr_ok && w_writable && waddr == raddr) ? wr_val : rd_cur;

    // Counters: a write to either half replaces it and suppresses that cycle's increment.
    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < 32; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (wr_ok && w_is_cnt && waddr[4:0] == 5'(i) && CNT_IMPL[i]) begin
                    if (waddr[7]) cnt_r[i][CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
                    else          cnt_r[i][31:0]           <= wdata;
                end else if (ev_vec[i] && !inhibit_r[i] && CNT_IMPL[i]) begin
                    cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Architectural CSRs: trap/mret take precedence over software writes.
    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            mstat_mie  <= 1'b0;
            mstat_mpie <= 1'b0;
            mie_r      <= '0;
            mtvec_r    <= '0;
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mtval_r    <= '0;
            inhibit_r  <= '0;
        end else if (ctrl_trap) begin
            if (ctrl_mret) begin
                mstat_mie  <= mstat_mpie;
                mstat_mpie <= 1'b1;
            end else begin
                mstat_mpie <= mstat_mie;
                mstat_mie  <= 1'b0;
                mepc_r     <= trap_pc;
                mcause_r   <= {trap_info[4], 27'b0, trap_info[3:0]};
            end
        end else if (wen) begin
            case (waddr)
                12'h300: begin
                    mstat_mie  <= wr_val[3];
                    mstat_mpie <= wr_val[7];
                end
                12'h304: mie_r      <= wr_val;
                12'h305: mtvec_r    <= wr_val;
                12'h320: inhibit_r  <= wr_val;
                12'h340: mscratch_r <= wr_val;
                12'h341: mepc_r     <= wr_val;
                12'h342: mcause_r   <= wr_val;
                12'h343: mtval_r    <= wr_val;
                default: ;
            endcase
        end
    end

    // Interrupt arbitration: MEI over MSI over MTI, only while globally enabled.
    always_comb begin
        irq_pending = mstat_mie & (|irq_en);
        irq_cause   = 4'd0;
        if (irq_pending) begin
            if      (irq_en[11]) irq_cause = 4'd11;
            else if (irq_en[3])  irq_cause = 4'd3;
            else                 irq_cause = 4'd7;
        end
    end

    assign ctrl_mie    = mstat_mie;
    assign mepc_out    = mepc_r;
    assign trap_target = {mtvec_r[31:2], 2'b00}
                       + ((mtvec_r[1:0] == 2'b01 && trap_info[4]) ? {26'h0, trap_info[3:0], 2'b00} : 32'h0);

endmodule
